// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage pipeline: load-use bubbles, memory-wait freeze, operand forwarding.
// Stall/forward outputs are combinational (Mealy) on the current stage tags; timeout flag is registered.
// Optional macro HAZARD_STATS_EN adds saturating stall/bubble statistics counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_rf_enable,
  input  logic                  i_ex_load_instr,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_rf_enable,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_rf_enable,
  input  logic                  i_mem_busy,
  output logic                  o_pc_le,
  output logic                  o_if_id_le,
  output logic                  o_id_ex_nop,
  output logic                  o_freeze,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic                  o_timeout_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_bubble_cnt
`endif
);

  localparam int WCNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_WAIT_MAX);

  // Reject configurations the counters cannot represent.
  if (MEM_WAIT_MAX < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_control_unit: MEM_WAIT_MAX and CNT_W must be >= 1");
  end

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_timeout_err;
  logic                w_lu;
  logic                w_bubble;

  // Forward select for one source operand; the younger MEM result beats WB, $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_en && (mem_rd != '0) && (mem_rd == src)) begin
      sel = 2'b01;
    end else if (wb_en && (wb_rd != '0) && (wb_rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    w_lu = i_ex_load_instr && i_ex_rf_enable && (i_ex_rd != '0) &&
           ((i_id_uses_rs && (i_id_rs == i_ex_rd)) ||
            (i_id_uses_rt && (i_id_rt == i_ex_rd)));
    // A busy memory freezes everything, so a bubble only happens in a non-busy cycle.
    w_bubble = w_lu && !i_mem_busy;
  end

  // Stall/bubble/forward outputs; reset overrides asynchronously.
  always_comb begin
    o_pc_le     = 1'b1;
    o_if_id_le  = 1'b1;
    o_id_ex_nop = 1'b0;
    o_freeze    = 1'b0;
    o_fwd_a     = fwd_sel(i_id_rs, i_mem_rf_enable, i_mem_rd, i_wb_rf_enable, i_wb_rd);
    o_fwd_b     = fwd_sel(i_id_rt, i_mem_rf_enable, i_mem_rd, i_wb_rf_enable, i_wb_rd);
    if (i_rst) begin
      o_pc_le     = 1'b0;
      o_if_id_le  = 1'b0;
      o_id_ex_nop = 1'b1;
      o_fwd_a     = 2'b00;
      o_fwd_b     = 2'b00;
    end else if (i_mem_busy) begin
      o_pc_le    = 1'b0;
      o_if_id_le = 1'b0;
      o_freeze   = 1'b1;
    end else if (w_bubble) begin
      o_pc_le     = 1'b0;
      o_if_id_le  = 1'b0;
      o_id_ex_nop = 1'b1;
    end
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:      if (i_mem_busy)  r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (!i_mem_busy) r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
      if (i_mem_busy) begin
        if (r_wait_cnt == WAIT_MAX) begin
          r_timeout_err <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating counts of freeze cycles and load-use bubbles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (i_mem_busy && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble && (r_bubble_cnt != '1))  r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized self-checking bench for hazard_control_unit against a rule-level reference model.
module tb_hazard_control_unit;
  localparam int RW = 5;
  localparam int WMAX = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          uses_rs, uses_rt, ex_rfen, ex_load, mem_rfen, wb_rfen, busy;
  logic          pc_le, if_id_le, id_ex_nop, freeze, tmo;
  logic [1:0]    fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  hazard_control_unit #(.REG_ADDR_W(RW), .MEM_WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_ex_rd(ex_rd), .i_ex_rf_enable(ex_rfen), .i_ex_load_instr(ex_load),
    .i_mem_rd(mem_rd), .i_mem_rf_enable(mem_rfen),
    .i_wb_rd(wb_rd), .i_wb_rf_enable(wb_rfen), .i_mem_busy(busy),
    .o_pc_le(pc_le), .o_if_id_le(if_id_le), .o_id_ex_nop(id_ex_nop), .o_freeze(freeze),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_timeout_err(tmo)
`ifdef HAZARD_STATS_EN
    , .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: consecutive busy edges, sticky timeout, statistics.
  int m_busy_run;
  bit m_tmo;
  int m_stalls;
  int m_bubbles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit lu_now();
    return ex_load && ex_rfen && (ex_rd != 0) &&
           ((uses_rs && id_rs == ex_rd) || (uses_rt && id_rt == ex_rd));
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [RW-1:0] src);
    if (mem_rfen && mem_rd != 0 && mem_rd == src) return 2'd1;
    if (wb_rfen && wb_rd != 0 && wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_busy_run = 0;
    m_tmo      = 0;
    m_stalls   = 0;
    m_bubbles  = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (busy) begin
      m_busy_run++;
      if (m_busy_run > WMAX) m_tmo = 1;
      if (m_stalls < (1 << CW) - 1) m_stalls++;
    end else begin
      m_busy_run = 0;
      if (lu_now() && m_bubbles < (1 << CW) - 1) m_bubbles++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic e_pc, e_nop, e_frz;
    logic [1:0] e_fa, e_fb;
    if (rst) model_reset();
    e_fa = fwd_ref(id_rs);
    e_fb = fwd_ref(id_rt);
    if (rst) begin
      e_pc = 0; e_nop = 1; e_frz = 0; e_fa = 0; e_fb = 0;
    end else if (busy) begin
      e_pc = 0; e_nop = 0; e_frz = 1;
    end else if (lu_now()) begin
      e_pc = 0; e_nop = 1; e_frz = 0;
    end else begin
      e_pc = 1; e_nop = 0; e_frz = 0;
    end
    check({tag, ".pc_le"}, pc_le, e_pc);
    check({tag, ".if_id_le"}, if_id_le, e_pc);
    check({tag, ".nop"}, id_ex_nop, e_nop);
    check({tag, ".freeze"}, freeze, e_frz);
    check({tag, ".fwd_a"}, fwd_a, e_fa);
    check({tag, ".fwd_b"}, fwd_b, e_fb);
    check({tag, ".tmo"}, tmo, m_tmo);
`ifdef HAZARD_STATS_EN
    check({tag, ".stall_cnt"}, stall_cnt, m_stalls);
    check({tag, ".bubble_cnt"}, bubble_cnt, m_bubbles);
`endif
  endtask

  // From a negedge: pass one rising edge, update the model, return at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    id_rs = 0; id_rt = 0; uses_rs = 0; uses_rt = 0;
    ex_rd = 0; ex_rfen = 0; ex_load = 0;
    mem_rd = 0; mem_rfen = 0; wb_rd = 0; wb_rfen = 0; busy = 0;
  endtask

  int burst_left;

  initial begin
    rst = 1;
    clr_inputs();
    model_reset();
    burst_left = 0;
    @(negedge clk);
    #1 check_outputs("reset");
    check("reset.pc_const", pc_le, 0);
    tick();

    // Release reset: normal flow immediately and next cycle.
    rst = 0;
    #1 check_outputs("release");
    check("release.pc_const", pc_le, 1);
    tick();
    #1 check_outputs("run1");

    // Load-use on $8: one bubble, then forwarding from MEM.
    tick();
    ex_load = 1; ex_rfen = 1; ex_rd = 8; id_rs = 8; uses_rs = 1;
    #1 check_outputs("lu");
    check("lu.nop_const", id_ex_nop, 1);
    tick();
    ex_load = 0; ex_rfen = 0; ex_rd = 0; mem_rd = 8; mem_rfen = 1;
    #1 check_outputs("lu_next");
    check("lu_next.fwd_a_const", fwd_a, 2'b01);

    // Forwarding priority and $0 exclusion on RT.
    tick();
    clr_inputs();
    mem_rd = 5; mem_rfen = 1; wb_rd = 5; wb_rfen = 1; id_rt = 5;
    #1 check_outputs("fwd_mem");
    check("fwd_mem.const", fwd_b, 2'b01);
    mem_rfen = 0;
    #1 check_outputs("fwd_wb");
    check("fwd_wb.const", fwd_b, 2'b10);
    id_rt = 0; mem_rd = 0; wb_rd = 0; mem_rfen = 1;
    #1 check_outputs("fwd_zero");
    check("fwd_zero.const", fwd_b, 2'b00);

    // Three busy cycles with a pending load-use, then one bubble.
    tick();
    clr_inputs();
    ex_load = 1; ex_rfen = 1; ex_rd = 9; id_rt = 9; uses_rt = 1;
    busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check_outputs("busy_lu");
      check("busy_lu.freeze_const", freeze, 1);
      tick();
    end
    busy = 0;
    #1 check_outputs("busy_lu_bubble");
    check("busy_lu_bubble.nop_const", id_ex_nop, 1);
    check("busy_lu.tmo_const", tmo, 0);
    tick();

    // Nine busy cycles: timeout appears only after the ninth edge and is sticky.
    clr_inputs();
    busy = 1;
    for (int i = 0; i < 9; i++) begin
      #1 check_outputs("long_busy");
      if (i == 8) check("long_busy.tmo8_const", tmo, 0);
      tick();
    end
    busy = 0;
    #1 check_outputs("timeout");
    check("timeout.const", tmo, 1);
    tick();
    #1 check_outputs("timeout_sticky");

    // Async reset mid-stall, then random traffic with occasional resets.
    busy = 1;
    #1 rst = 1;
    #1 check_outputs("mid_rst");
    check("mid_rst.tmo_const", tmo, 0);
    tick();
    rst = 0;
    busy = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      id_rs    = RW'($urandom_range(0, 3));
      id_rt    = RW'($urandom_range(0, 3));
      ex_rd    = RW'($urandom_range(0, 3));
      mem_rd   = RW'($urandom_range(0, 3));
      wb_rd    = RW'($urandom_range(0, 3));
      uses_rs  = 1'($urandom);
      uses_rt  = 1'($urandom);
      ex_rfen  = 1'($urandom);
      ex_load  = 1'($urandom);
      mem_rfen = 1'($urandom);
      wb_rfen  = 1'($urandom);
      if (burst_left == 0 && $urandom_range(0, 7) == 0) burst_left = $urandom_range(1, 12);
      busy = (burst_left > 0);
      if (burst_left > 0) burst_left--;
      rst = ($urandom_range(0, 199) == 0);
      if (rst) burst_left = 0;
      #2 check_outputs("rand");
      tick();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
